sf_generation_nch: RTL and testbench
====================================

# sf_generation_nch

Multi-channel, parametrised successor to the single-channel scale-factor generator in the openCV pipeline. It takes a signed gradient pair (dx, dy) per channel and computes magnitude fs = floor(sqrt(dx²+dy²)) plus unit-normalised components fx = dx/fs and fy = dy/fs in signed Q1.FRAC_W. Channels are processed sequentially by one shared bit-serial sqrt/divide datapath. Results are committed together at the end of a job.

## Interface
- DATA_W, 16, width of signed dx/dy and unsigned fs
- CH, 4, channel count (≥1)
- FRAC_W, 8, fractional bits of fx/fy
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  job request; sampled only in S_Ready
- dx_i  in  CH*DATA_W  signed dx, channel c at bits [c*DATA_W +: DATA_W]
- dy_i  in  CH*DATA_W  signed dy, same packing
- ready_o  out  1  high only in S_Ready
- done_o  out  1  one-cycle pulse when results are committed
- fs_o  out  CH*DATA_W  unsigned magnitude per channel
- fx_o  out  CH*(FRAC_W+2)  signed Q1.FRAC_W per channel
- fy_o  out  CH*(FRAC_W+2)  signed Q1.FRAC_W per channel

## Operation
- States: S_Reset, S_Ready, S_SUMSQ, S_DXYP5, S_FXNORM, S_FYNORM, S_FS, S_Done.
- Reset: rst_n low forces S_Reset; all outputs and internal registers are cleared to 0, and ready_o/done_o are 0. S_Reset always goes to S_Ready on the next cycle.
- S_Ready: start_i=1 latches all dx_i/dy_i, sets channel index to 0, and goes to S_SUMSQ. start_i outside S_Ready is ignored and not queued.
- S_SUMSQ: 1 cycle. Computes sq = dx²+dy² as an unsigned 2*DATA_W-bit value. The maximum, 2^(2*DATA_W−1), fits.
- S_DXYP5: restoring integer square root, one result bit per cycle, DATA_W cycles. The result is mag = floor(sqrt(sq)) in DATA_W bits.
  - If mag==0, fx and fy are forced to 0 and the FSM goes directly to S_FS.
- S_FXNORM / S_FYNORM: sequential restoring divide of (|d| << FRAC_W) by mag, DATA_W+FRAC_W cycles each.
  - The sign of d is applied afterwards.
  - The magnitude never exceeds 2^FRAC_W, so the result fits FRAC_W+2 signed bits.
- S_FS: 1 cycle. Writes fs/fx/fy to per-channel shadow registers.
  - If the channel index is < CH−1, increment it and go to S_SUMSQ.
  - Otherwise go to S_Done.
- S_Done: 1 cycle. Copies all shadow registers to the outputs together and pulses done_o, then returns to S_Ready.
- Outputs hold their values until the next S_Done or reset.

## Timing
- Per-channel cycles without rounding: Tc = 2 + DATA_W + 2*(DATA_W+FRAC_W). With the defaults Tc = 66.
- When mag==0: Tc0 = 2 + DATA_W, which is 18 with the defaults.
- Job latency from the start_i sample edge to done_o high is ΣTc over all channels, plus 1. With the defaults and all channels nonzero this is 4*66+1 = 265 cycles.
- ready_o rises in the cycle after done_o. A back-to-back start_i is accepted on that cycle.
- Reset mid-job aborts the job: the outputs clear to 0 and no done_o is produced.

## Configuration
- SF_GEN_ROUND_EN defined:
  - Each divide computes one extra quotient bit, adding 1 cycle to each of S_FXNORM and S_FYNORM.
  - fx/fy are rounded half-away-from-zero.
  - Tc becomes 68 with the defaults. Tc0 is unchanged.
- SF_GEN_ROUND_EN undefined: fx/fy truncate toward zero. fs always truncates.

## Structure
- Package pkg_sf_generation_nch holds:
  - the STATES_t enum (logic [3:0]) with the states listed above;
  - the localparam helper functions for output widths (FRAC_W+2) and divide length.
- The package imports globalDefinitions.
- Sub-module sf_seq_div: start/busy/done restoring divider, parametrised on dividend width and divisor width. It is instantiated once and shared by S_FXNORM and S_FYNORM.
- The sqrt stays inline in the top-level FSM.

## Test plan
- Ch0 dx=3, dy=4 → fs=5, fx=153, fy=204. With SF_GEN_ROUND_EN: fx=154, fy=205. done_o occurs exactly 265 cycles after start, or 273 cycles with SF_GEN_ROUND_EN.
- All channels dx=0, dy=0 → fs=fx=fy=0. done_o occurs 4*18+1 = 73 cycles after start.
- dx=−32768, dy=−32768 → fs=46340, fx=fy=−181. This checks the width and sign extremes.
- Mixed channels: dx=+5/dy=0 → fx=+256, fy=0. dx=0/dy=−7 → fx=0, fy=−256. Each result appears only on its own channel slice.
- start_i held high throughout the job → exactly one job runs. Back-to-back jobs start on the ready_o cycle.
- rst_n low at cycle 100 of a job → outputs read 0 on the next cycle and no done_o appears. ready_o is high 2 cycles after rst_n returns high.

Source files
------------

// File: rtl/sf_generation_nch_pkg.sv
// Shared definitions for the multi-channel scale-factor generator.
// SF_GEN_ROUND_EN adds one quotient bit per divide for half-away-from-zero rounding.
package globalDefinitions;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

package pkg_sf_generation_nch;
    import globalDefinitions::*;

    typedef enum logic [3:0] {
        S_Reset  = 4'd0,
        S_Ready  = 4'd1,
        S_SUMSQ  = 4'd2,
        S_DXYP5  = 4'd3,
        S_FXNORM = 4'd4,
        S_FYNORM = 4'd5,
        S_FS     = 4'd6,
        S_Done   = 4'd7
    } STATES_t;

`ifdef SF_GEN_ROUND_EN
    localparam int unsigned RND_BITS = 1;
`else
    localparam int unsigned RND_BITS = 0;
`endif

    function automatic int unsigned norm_width(input int unsigned frac_w);
        return frac_w + 2;
    endfunction

    function automatic int unsigned div_len(input int unsigned data_w, input int unsigned frac_w);
        return data_w + frac_w + RND_BITS;
    endfunction

endpackage

// File: rtl/sf_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle, DIVIDEND_W cycles per job.
// The start cycle already performs the first step so the job occupies exactly DIVIDEND_W cycles.
module sf_seq_div #(
    parameter int unsigned DIVIDEND_W = 24,
    parameter int unsigned DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);
    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo;
    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dsr;
    logic [CNT_W-1:0]      cnt;

    logic [DIVIDEND_W-1:0] src_q;
    logic [DIVISOR_W-1:0]  src_r;
    logic [DIVISOR_W-1:0]  src_d;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic                  ge;
    logic [DIVISOR_W-1:0]  rem_nx;
    logic [DIVIDEND_W-1:0] quo_nx;

    always_comb begin
        src_q  = start ? dividend : quo;
        src_r  = start ? '0 : rem;
        src_d  = start ? divisor : dsr;
        trial  = {src_r, src_q[DIVIDEND_W-1]};
        diff   = trial - {1'b0, src_d};
        ge     = (trial >= {1'b0, src_d});
        rem_nx = ge ? DIVISOR_W'(diff) : DIVISOR_W'(trial);
        quo_nx = {src_q[DIVIDEND_W-2:0], ge};
    end

    assign done     = busy && (cnt == CNT_W'(DIVIDEND_W - 1));
    assign quotient = quo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo  <= '0;
            rem  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            quo  <= quo_nx;
            rem  <= rem_nx;
            dsr  <= divisor;
            cnt  <= CNT_W'(1);
            busy <= 1'b1;
        end else if (busy) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/sf_generation_nch.sv
// Multi-channel scale-factor generator: fs = floor(sqrt(dx^2+dy^2)), fx = dx/fs, fy = dy/fs.
// SF_GEN_ROUND_EN selects half-away-from-zero rounding of fx/fy (default: truncate).
module sf_generation_nch
    import globalDefinitions::*;
    import pkg_sf_generation_nch::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH     = 4,
    parameter int unsigned FRAC_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [CH*DATA_W-1:0]          dx_i,
    input  logic [CH*DATA_W-1:0]          dy_i,
    output logic                          ready_o,
    output logic                          done_o,
    output logic [CH*DATA_W-1:0]          fs_o,
    output logic [CH*(FRAC_W+2)-1:0]      fx_o,
    output logic [CH*(FRAC_W+2)-1:0]      fy_o
);
    localparam int unsigned OW    = norm_width(FRAC_W);
    localparam int unsigned DIV_N = div_len(DATA_W, FRAC_W);
    localparam int unsigned CH_W  = idx_width(CH);
    localparam int unsigned SQ_W  = 2 * DATA_W;
    localparam int unsigned REM_W = DATA_W + 3;
    localparam int unsigned SC_W  = idx_width(DATA_W);

    STATES_t           state;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] dx_lat [CH];
    logic [DATA_W-1:0] dy_lat [CH];
    logic [SQ_W-1:0]   rad;
    logic [REM_W-1:0]  rem;
    logic [DATA_W-1:0] root;
    logic [DATA_W-1:0] mag;
    logic [SC_W-1:0]   sq_cnt;
    logic [OW-1:0]     fx_r;
    logic [DATA_W-1:0] fs_sh [CH];
    logic [OW-1:0]     fx_sh [CH];
    logic [OW-1:0]     fy_sh [CH];

    logic [DATA_W-1:0]      cur_dx, cur_dy, dx_abs, dy_abs;
    logic                   dx_neg, dy_neg;
    logic signed [SQ_W-1:0] dxe, dye, px, py;
    logic [SQ_W-1:0]        sq_cur;
    logic [REM_W+1:0]       rem_sh, trial;
    logic                   sq_ge;
    logic [REM_W-1:0]       rem_nx;
    logic [DATA_W-1:0]      root_nx;

    logic             div_start, div_busy, div_done;
    logic [DIV_N-1:0] div_dividend, div_quo;

    function automatic logic [OW-1:0] norm_val(input logic [DIV_N-1:0] q, input logic neg);
        logic [DIV_N-1:0] m;
`ifdef SF_GEN_ROUND_EN
        m = (q + DIV_N'(1)) >> 1;
`else
        m = q;
`endif
        return OW'(neg ? (~m + 1'b1) : m);
    endfunction

    always_comb begin
        cur_dx  = dx_lat[ch];
        cur_dy  = dy_lat[ch];
        dx_neg  = cur_dx[DATA_W-1];
        dy_neg  = cur_dy[DATA_W-1];
        dx_abs  = dx_neg ? (~cur_dx + 1'b1) : cur_dx;
        dy_abs  = dy_neg ? (~cur_dy + 1'b1) : cur_dy;
        dxe     = {{DATA_W{cur_dx[DATA_W-1]}}, cur_dx};
        dye     = {{DATA_W{cur_dy[DATA_W-1]}}, cur_dy};
        px      = dxe * dxe;
        py      = dye * dye;
        sq_cur  = $unsigned(px) + $unsigned(py);
        // Square root: bring down two radicand bits, try (root<<2)|1 against the remainder.
        rem_sh  = {rem, rad[SQ_W-1 -: 2]};
        trial   = (REM_W + 2)'({root, 2'b01});
        sq_ge   = (rem_sh >= trial);
        rem_nx  = REM_W'(sq_ge ? (rem_sh - trial) : rem_sh);
        root_nx = DATA_W'({root, sq_ge});
    end

    assign div_start    = ((state == S_FXNORM) || (state == S_FYNORM)) && !div_busy;
    assign div_dividend = {((state == S_FYNORM) ? dy_abs : dx_abs), {(FRAC_W + RND_BITS){1'b0}}};

    sf_seq_div #(
        .DIVIDEND_W (DIV_N),
        .DIVISOR_W  (DATA_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (mag),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_Reset;
            ch      <= '0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            mag     <= '0;
            sq_cnt  <= '0;
            fx_r    <= '0;
            ready_o <= 1'b0;
            done_o  <= 1'b0;
            fs_o    <= '0;
            fx_o    <= '0;
            fy_o    <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                dx_lat[c] <= '0;
                dy_lat[c] <= '0;
                fs_sh[c]  <= '0;
                fx_sh[c]  <= '0;
                fy_sh[c]  <= '0;
            end
        end else begin
            done_o <= 1'b0;
            case (state)
                S_Reset: state <= S_Ready;
                // ready_o lags entry by one cycle; start is honoured only once it is visible.
                S_Ready: begin
                    if (ready_o && start_i) begin
                        for (int unsigned c = 0; c < CH; c++) begin
                            dx_lat[c] <= dx_i[c*DATA_W +: DATA_W];
                            dy_lat[c] <= dy_i[c*DATA_W +: DATA_W];
                        end
                        ch      <= '0;
                        ready_o <= 1'b0;
                        state   <= S_SUMSQ;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                S_SUMSQ: begin
                    rad    <= sq_cur;
                    rem    <= '0;
                    root   <= '0;
                    sq_cnt <= '0;
                    state  <= S_DXYP5;
                end
                S_DXYP5: begin
                    rad    <= rad << 2;
                    rem    <= rem_nx;
                    root   <= root_nx;
                    sq_cnt <= sq_cnt + 1'b1;
                    if (sq_cnt == SC_W'(DATA_W - 1)) begin
                        mag   <= root_nx;
                        state <= (root_nx == '0) ? S_FS : S_FXNORM;
                    end
                end
                S_FXNORM: begin
                    if (div_done)
                        state <= S_FYNORM;
                end
                S_FYNORM: begin
                    if (!div_busy)
                        fx_r <= norm_val(div_quo, dx_neg);
                    if (div_done)
                        state <= S_FS;
                end
                S_FS: begin
                    fs_sh[ch] <= mag;
                    fx_sh[ch] <= (mag == '0) ? '0 : fx_r;
                    fy_sh[ch] <= (mag == '0) ? '0 : norm_val(div_quo, dy_neg);
                    if (ch == CH_W'(CH - 1)) begin
                        state <= S_Done;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= S_SUMSQ;
                    end
                end
                S_Done: begin
                    for (int unsigned c = 0; c < CH; c++) begin
                        fs_o[c*DATA_W +: DATA_W] <= fs_sh[c];
                        fx_o[c*OW +: OW]         <= fx_sh[c];
                        fy_o[c*OW +: OW]         <= fy_sh[c];
                    end
                    done_o <= 1'b1;
                    state  <= S_Ready;
                end
                default: state <= S_Reset;
            endcase
        end
    end

endmodule

// File: tb/tb_sf_generation_nch.sv
// Scoreboard bench for sf_generation_nch; honours SF_GEN_ROUND_EN for expected fx/fy and timing.
module tb_sf_generation_nch;
    localparam int DATA_W = 16;
    localparam int CH     = 4;
    localparam int FRAC_W = 8;
    localparam int OW     = FRAC_W + 2;
`ifdef SF_GEN_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start_i;
    logic [CH*DATA_W-1:0] dx_i, dy_i;
    logic                 ready_o, done_o;
    logic [CH*DATA_W-1:0] fs_o;
    logic [CH*OW-1:0]     fx_o, fy_o;

    sf_generation_nch #(
        .DATA_W (DATA_W),
        .CH     (CH),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .dx_i    (dx_i),
        .dy_i    (dy_i),
        .ready_o (ready_o),
        .done_o  (done_o),
        .fs_o    (fs_o),
        .fx_o    (fx_o),
        .fy_o    (fy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]          due;
        logic [CH*DATA_W-1:0] fs;
        logic [CH*OW-1:0]     fx;
        logic [CH*OW-1:0]     fy;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt(input longint v);
        int s;
        s = int'($floor($sqrt(real'(v))));
        while (longint'(s) * s > v) s--;
        while (longint'(s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    // Q1.FRAC_W ratio d/fs; rounding is half away from zero on the magnitude.
    function automatic int norm(input int d, input int fs);
        int a;
        if (fs == 0) return 0;
        a = (d < 0) ? -d : d;
        if (RND != 0) a = (2 * a * (1 << FRAC_W) + fs) / (2 * fs);
        else          a = (a * (1 << FRAC_W)) / fs;
        return (d < 0) ? -a : a;
    endfunction

    task automatic issue(input logic [CH*DATA_W-1:0] dxv, input logic [CH*DATA_W-1:0] dyv,
                         input bit hold, output int acc);
        exp_t e;
        int   n, lat, fs;
        logic signed [DATA_W-1:0] sx, sy;
        dx_i = dxv;
        dy_i = dyv;
        start_i = 1'b1;
        n = 0;
        while (!ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("ready_wait_timeout", 0, 1);
        lat = 1;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            sx = dxv[c*DATA_W +: DATA_W];
            sy = dyv[c*DATA_W +: DATA_W];
            fs = isqrt(longint'(sx) * sx + longint'(sy) * sy);
            e.fs[c*DATA_W +: DATA_W] = DATA_W'(fs);
            e.fx[c*OW +: OW]         = OW'(norm(int'(sx), fs));
            e.fy[c*OW +: OW]         = OW'(norm(int'(sy), fs));
            lat += (fs == 0) ? (2 + DATA_W) : (2 + DATA_W + 2 * (DATA_W + FRAC_W + RND));
        end
        @(posedge clk);
        #1;
        acc = cyc;
        e.due = 32'(acc + lat);
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        while (!done_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) chk("done_wait_timeout", 0, 1);
        dc = cyc;
    endtask

    function automatic logic [CH*DATA_W-1:0] rand_vec();
        logic [CH*DATA_W-1:0] v;
        for (int c = 0; c < CH; c++) begin
            case ($urandom_range(0, 7))
                0:       v[c*DATA_W +: DATA_W] = '0;
                1:       v[c*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 40) - 20);
                default: v[c*DATA_W +: DATA_W] = DATA_W'($urandom);
            endcase
        end
        return v;
    endfunction

    function automatic logic [CH*DATA_W-1:0] rand_full();
        logic [CH*DATA_W-1:0] v;
        for (int c = 0; c < CH; c++)
            v[c*DATA_W +: DATA_W] = DATA_W'($urandom_range(1, 30000));
        return v;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, longint'(e.due));
                    for (int c = 0; c < CH; c++) begin
                        chk($sformatf("fs[%0d]", c), fs_o[c*DATA_W +: DATA_W], e.fs[c*DATA_W +: DATA_W]);
                        chk($sformatf("fx[%0d]", c), fx_o[c*OW +: OW], e.fx[c*OW +: OW]);
                        chk($sformatf("fy[%0d]", c), fy_o[c*OW +: OW], e.fy[c*OW +: OW]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [CH*DATA_W-1:0] vx, vy;
        int acc, acc2, dc;
        rst_n   = 1'b0;
        start_i = 1'b0;
        dx_i    = '0;
        dy_i    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_fs", fs_o, 0);
        chk("rst_fx", fx_o, 0);
        chk("rst_fy", fy_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst_1", ready_o, 0);
        @(negedge clk);
        chk("ready_after_rst_2", ready_o, 1);

        // 3/4 triangle on channel 0, nonzero elsewhere
        vx = rand_full();
        vy = rand_full();
        vx[DATA_W-1:0] = 16'd3;
        vy[DATA_W-1:0] = 16'd4;
        issue(vx, vy, 1'b0, acc);
        wait_done(dc);
        chk("lat_3_4", dc - acc, (RND != 0) ? 273 : 265);
        chk("k_fs0", fs_o[DATA_W-1:0], 5);
        chk("k_fx0", fx_o[OW-1:0], (RND != 0) ? 154 : 153);
        chk("k_fy0", fy_o[OW-1:0], (RND != 0) ? 205 : 204);

        // all-zero job
        issue('0, '0, 1'b0, acc);
        wait_done(dc);
        chk("lat_zero", dc - acc, 73);

        // most-negative inputs
        issue({CH{16'h8000}}, {CH{16'h8000}}, 1'b0, acc);
        wait_done(dc);
        chk("k_fs_ext", fs_o[DATA_W-1:0], 46340);
        chk("k_fx_ext", fx_o[OW-1:0], 10'h3FF & (1024 - 181));

        // mixed channel patterns
        vx = {16'd1000, 16'd0, 16'd0, 16'd5};
        vy = {16'hF000, 16'd0, 16'hFFF9, 16'd0};
        issue(vx, vy, 1'b0, acc);
        wait_done(dc);
        chk("k_fx_axis", fx_o[OW-1:0], 256);
        chk("k_fy_axis", fy_o[2*OW-1:OW], 1024 - 256);

        // start held high across the whole job
        issue(rand_full(), rand_full(), 1'b1, acc);
        wait_done(dc);
        start_i = 1'b0;
        chk("ready_at_done", ready_o, 0);
        @(negedge clk);
        chk("ready_after_done", ready_o, 1);
        repeat (300) @(negedge clk);

        // back-to-back jobs
        issue(rand_vec(), rand_vec(), 1'b0, acc);
        wait_done(dc);
        issue(rand_vec(), rand_vec(), 1'b0, acc2);
        chk("b2b_accept_gap", acc2 - dc, 2);
        wait_done(dc);

        for (int i = 0; i < 6; i++) begin
            issue(rand_vec(), rand_vec(), 1'b0, acc);
            wait_done(dc);
        end

        // reset in the middle of a job
        issue(rand_full(), rand_full(), 1'b0, acc);
        while (cyc < acc + 99) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_fs", fs_o, 0);
        chk("midrst_fx", fx_o, 0);
        chk("midrst_fy", fy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_ready", ready_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_1", ready_o, 0);
        @(negedge clk);
        chk("midrst_ready_2", ready_o, 1);
        repeat (400) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
